// File: rtl/fp16_pkg.sv
// ---------------------------------------------------------------------------
// fp16_pkg
//   Shared fp16 definitions for the dot-product accumulator: field widths,
//   exponent bias, the largest finite magnitude, field-extract helpers and
//   the accumulator FSM state encoding.
//   fp16 layout: sign[15], exp[14:10] (bias 15), frac[9:0].
// ---------------------------------------------------------------------------
package fp16_pkg;

   localparam int          FP16_EXP_W   = 5;
   localparam int          FP16_FRAC_W  = 10;
   localparam int          FP16_BIAS    = 15;
   localparam logic [14:0] FP16_MAX_FIN = 15'h7BFF;

   typedef enum logic [2:0] {
      ST_WAIT,
      ST_ALIGN,
      ST_ADD,
      ST_NORM,
      ST_OUT
   } state_e;

   function automatic logic fp16_sign(input logic [15:0] x);
      return x[15];
   endfunction

   function automatic logic [FP16_EXP_W-1:0] fp16_exp(input logic [15:0] x);
      return x[14:10];
   endfunction

   function automatic logic [FP16_FRAC_W-1:0] fp16_frac(input logic [15:0] x);
      return x[9:0];
   endfunction

   // exp==0 encodes zero; subnormals are flushed to zero as well.
   function automatic logic fp16_is_zero(input logic [15:0] x);
      return (x[14:10] == '0);
   endfunction

endpackage

// File: rtl/fp16_lzc.sv
// ---------------------------------------------------------------------------
// fp16_lzc
//   Combinational leading-zero counter. Counts zeros from the MSB of data_i
//   down to the first set bit; an all-zero input returns W.
// Ports:
//   data_i   in   W    word to scan
//   count_o  out  CW   number of leading zeros (0..W)
// ---------------------------------------------------------------------------
module fp16_lzc #(
   parameter int W  = 15,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  data_i,
   output logic [CW-1:0] count_o
);

   // NOTE: the output is assigned a default before the loop, so every path
   // drives it and no latch is inferred.
   always_comb begin
      count_o = CW'(W);
      // Scanning upward lets the highest set bit overwrite lower ones.
      for (int i = 0; i < W; i++) begin
         if (data_i[i]) count_o = CW'(W - 1 - i);
      end
   end

endmodule

// File: rtl/fp16_dot_acc.sv
// ---------------------------------------------------------------------------
// fp16_dot_acc
//   Sums a packet of fp16 products (closed by in_last_i) through a four-step
//   ALIGN/ADD/NORM datapath and returns one fp16 sum plus the element count
//   per packet. One product is accepted every four cycles.
//   Build option: define FP16_DOT_ACC_RNE_EN for round-to-nearest-even;
//   otherwise results are truncated (round toward zero).
// Ports:
//   clk          in   1      clock, rising edge
//   rst_n        in   1      synchronous active-low reset
//   in_valid_i   in   1      product valid
//   in_ready_o   out  1      product can be accepted (state WAIT)
//   in_data_i    in   16     fp16 product
//   in_last_i    in   1      final product of a packet
//   out_valid_o  out  1      result valid
//   out_ready_i  in   1      consumer accepts result
//   out_sum_o    out  16     fp16 packet sum
//   out_count_o  out  CNT_W  products in the packet (saturating)
// ---------------------------------------------------------------------------
module fp16_dot_acc
   import fp16_pkg::*;
#(
   parameter int CNT_W = 8,
   parameter int GRD_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [15:0]      in_data_i,
   input  logic             in_last_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [15:0]      out_sum_o,
   output logic [CNT_W-1:0] out_count_o
);

   localparam int MW  = 11 + GRD_W;       // hidden bit + frac + guard bits
   localparam int SW  = MW + 1;           // sum with carry-out
   localparam int LZW = $clog2(SW + 1);
   localparam int EW  = 8;                // signed working exponent

   state_e           state_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [15:0]      out_sum_q;
   logic [CNT_W-1:0] out_count_q;
   logic [15:0]      acc_q;
   logic [CNT_W-1:0] cnt_q;

   logic [15:0]      in_data_q;
   logic             in_last_q;
   logic             a_sign_q;
   logic             b_sign_q;
   logic [4:0]       a_exp_q;
   logic [MW-1:0]    a_man_q;
   logic [MW-1:0]    b_man_q;
   logic [SW-1:0]    sum_q;

   // ------------------------------------------------------------------
   // ALIGN: order operands by magnitude, shift the smaller one right.
   // ------------------------------------------------------------------
   logic [14:0]   x_mag;
   logic [14:0]   y_mag;
   logic          swap;
   logic [15:0]   op_a;
   logic [15:0]   op_b;
   logic [4:0]    exp_diff;
   logic [MW-1:0] a_man_d;
   logic [MW-1:0] b_man_raw;
   logic [MW-1:0] b_man_d;

   always_comb begin
      x_mag     = fp16_is_zero(acc_q)     ? '0 : acc_q[14:0];
      y_mag     = fp16_is_zero(in_data_q) ? '0 : in_data_q[14:0];
      swap      = (y_mag > x_mag);
      op_a      = swap ? {fp16_sign(in_data_q), y_mag} : {fp16_sign(acc_q), x_mag};
      op_b      = swap ? {fp16_sign(acc_q), x_mag} : {fp16_sign(in_data_q), y_mag};
      a_man_d   = (op_a[14:0] == '0) ? '0 : {1'b1, fp16_frac(op_a), {GRD_W{1'b0}}};
      b_man_raw = (op_b[14:0] == '0) ? '0 : {1'b1, fp16_frac(op_b), {GRD_W{1'b0}}};
      exp_diff  = fp16_exp(op_a) - fp16_exp(op_b);
      if (32'(exp_diff) >= MW) begin
         // Everything falls off the end; only the sticky bit survives.
         b_man_d = {{(MW-1){1'b0}}, |b_man_raw};
      end else begin
         b_man_d    = b_man_raw >> exp_diff;
         b_man_d[0] = b_man_d[0] | (|(b_man_raw & ~({MW{1'b1}} << exp_diff)));
      end
   end

   // ------------------------------------------------------------------
   // NORM: normalise, round, then clamp to zero / max finite.
   // ------------------------------------------------------------------
   logic [LZW-1:0]       lzc;
   logic [SW-1:0]        sum_shl;
   logic [MW-1:0]        norm_man;
   logic signed [EW-1:0] norm_exp;
   logic signed [EW-1:0] res_exp;
   logic                 rnd_up;
   logic [11:0]          rnd_man;
   logic [15:0]          res_d;
   logic [CNT_W-1:0]     cnt_inc;

   fp16_lzc #(
      .W  (SW),
      .CW (LZW)
   ) u_lzc (
      .data_i  (sum_q),
      .count_o (lzc)
   );

   always_comb begin
      // Shifting so the leading one lands in the carry position covers both
      // cases: lzc=0 (carry-out) folds bit 0 into sticky, lzc>0 shifts in zeros.
      sum_shl  = sum_q << lzc;
      norm_man = {sum_shl[SW-1:2], sum_shl[1] | sum_shl[0]};
      norm_exp = EW'(a_exp_q) + EW'(1) - EW'(lzc);
`ifdef FP16_DOT_ACC_RNE_EN
      rnd_up   = norm_man[GRD_W-1] & ((|norm_man[GRD_W-2:0]) | norm_man[GRD_W]);
`else
      rnd_up   = 1'b0;
`endif
      rnd_man  = {1'b0, norm_man[MW-1:GRD_W]} + 12'(rnd_up);
      res_exp  = rnd_man[11] ? norm_exp + EW'(1) : norm_exp;
      if (sum_q == '0 || res_exp <= 0) begin
         res_d = 16'h0000;
      end else if (res_exp >= 31) begin
         res_d = {a_sign_q, FP16_MAX_FIN};
      end else begin
         res_d = {a_sign_q, res_exp[4:0], (rnd_man[11] ? rnd_man[10:1] : rnd_man[9:0])};
      end
      cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
   end

   // ------------------------------------------------------------------
   // Control FSM and architectural state.
   // ------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_WAIT;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_count_q <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            ST_WAIT: begin
               if (in_valid_i) begin
                  state_q    <= ST_ALIGN;
                  in_ready_q <= 1'b0;
               end
            end
            ST_ALIGN: state_q <= ST_ADD;
            ST_ADD:   state_q <= ST_NORM;
            ST_NORM: begin
               acc_q <= res_d;
               cnt_q <= cnt_inc;
               if (in_last_q) begin
                  state_q     <= ST_OUT;
                  out_valid_q <= 1'b1;
                  out_sum_q   <= res_d;
                  out_count_q <= cnt_inc;
               end else begin
                  state_q    <= ST_WAIT;
                  in_ready_q <= 1'b1;
               end
            end
            ST_OUT: begin
               if (out_ready_i) begin
                  state_q     <= ST_WAIT;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
                  acc_q       <= '0;
                  cnt_q       <= '0;
               end
            end
            default: begin
               state_q    <= ST_WAIT;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   // NOTE: the staging registers below carry no reset; each is written in the
   // state before the one that reads it, so stale contents are never used.
   always_ff @(posedge clk) begin
      if (state_q == ST_WAIT && in_valid_i) begin
         in_data_q <= in_data_i;
         in_last_q <= in_last_i;
      end
      if (state_q == ST_ALIGN) begin
         a_sign_q <= fp16_sign(op_a);
         b_sign_q <= fp16_sign(op_b);
         a_exp_q  <= fp16_exp(op_a);
         a_man_q  <= a_man_d;
         b_man_q  <= b_man_d;
      end
      if (state_q == ST_ADD) begin
         // |A| >= |B| after ALIGN, so the difference never goes negative.
         sum_q <= (a_sign_q == b_sign_q) ? ({1'b0, a_man_q} + {1'b0, b_man_q})
                                         : ({1'b0, a_man_q} - {1'b0, b_man_q});
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_sum_o   = out_sum_q;
   assign out_count_o = out_count_q;

endmodule

// File: tb/tb_fp16_dot_acc.sv
// ---------------------------------------------------------------------------
// tb_fp16_dot_acc
//   Directed and random packets for fp16_dot_acc. Expected sums come from an
//   exact-arithmetic model: each fp16 value is held as a signed integer
//   multiple of 2**-24, summed exactly, then rounded back to fp16.
// ---------------------------------------------------------------------------
module tb_fp16_dot_acc;
   import fp16_pkg::*;

   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic             in_valid  = 1'b0;
   logic             in_last   = 1'b0;
   logic [15:0]      in_data   = '0;
   logic             out_ready = 1'b0;
   logic             in_ready;
   logic             out_valid;
   logic [15:0]      out_sum;
   logic [CNT_W-1:0] out_count;

   int          n_checks  = 0;
   int          n_pass    = 0;
   int          n_fail    = 0;
   int          last_wait = 0;
   logic [15:0] model_acc = '0;
   int          model_cnt = 0;
   logic [15:0] got_sum;

   fp16_dot_acc #(
      .CNT_W (CNT_W),
      .GRD_W (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .in_last_i   (in_last),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_sum_o   (out_sum),
      .out_count_o (out_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Exact value in units of 2**-24; exp==0 is zero.
   function automatic longint fp_val(input logic [15:0] h);
      longint v;
      int     e;
      e = int'(h[14:10]);
      if (e == 0) return 0;
      v = longint'({1'b1, h[9:0]}) << (e + 24 - FP16_BIAS - 10);
      return h[15] ? -v : v;
   endfunction

   function automatic logic [15:0] to_fp16(input longint n);
      longint mag;
      longint m;
      int     p;
      int     e;
      int     sh;
      logic   s;
`ifdef FP16_DOT_ACC_RNE_EN
      longint rem;
      longint half;
`endif
      if (n == 0) return 16'h0000;
      s   = (n < 0);
      mag = s ? -n : n;
      p   = 0;
      for (int i = 0; i < 63; i++) if (mag[i]) p = i;
      e = p - 24 + FP16_BIAS;
      if (p >= 10) begin
         sh = p - 10;
         m  = mag >> sh;
`ifdef FP16_DOT_ACC_RNE_EN
         if (sh > 0) begin
            rem  = mag - (m << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && m[0])) m++;
         end
`endif
      end else begin
         m = mag << (10 - p);
      end
      if (m == 2048) begin
         m = 1024;
         e++;
      end
      if (e <= 0) return 16'h0000;
      if (e >= 31) return s ? 16'hFBFF : 16'h7BFF;
      return {s, 5'(e), 10'(m)};
   endfunction

   function automatic logic [15:0] rnd_fp();
      logic [15:0] r;
      r = 16'($urandom);
      if ($urandom_range(1, 0) == 1) r[14:10] = 5'($urandom_range(18, 12));
      return r;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [15:0] d, input logic last);
      int waited = 0;
      while (in_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      last_wait = waited;
      check("in_ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      model_acc = to_fp16(fp_val(model_acc) + fp_val(d));
      if (model_cnt < CNT_MAX) model_cnt++;
   endtask

   // Called right after the last send; checks latency, result and hold.
   task automatic collect(input string tag, input int hold);
      int lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_valid"},   32'(out_valid), 32'd1);
      check({tag, "_latency"}, 32'(lat),       32'd3);
      check({tag, "_sum"},     32'(out_sum),   32'(model_acc));
      check({tag, "_count"},   32'(out_count), 32'(model_cnt));
      got_sum = out_sum;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_sum"},   32'(out_sum),   32'(model_acc));
         check({tag, "_hold_count"}, 32'(out_count), 32'(model_cnt));
         check({tag, "_hold_ready"}, 32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_ack_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_ack_ready"}, 32'(in_ready),  32'd1);
      model_acc = '0;
      model_cnt = 0;
   endtask

   initial begin
      // Reset.
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sum",   32'(out_sum),   32'd0);
      check("rst_out_count", 32'(out_count), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);

      // 1) 1 + 2 + 3 = 6.
      send(16'h3C00, 1'b0);
      send(16'h4000, 1'b0);
      check("t1_throughput", 32'(last_wait), 32'd3);
      send(16'h4200, 1'b1);
      collect("t1", 0);
      check("t1_const", 32'(got_sum), 32'h4600);

      // 2) exact cancellation.
      send(16'h4500, 1'b0);
      send(16'hC500, 1'b1);
      collect("t2", 0);
      check("t2_const", 32'(got_sum), 32'h0000);

      // 3) saturation, both signs.
      send(16'h7BFF, 1'b0);
      send(16'h7BFF, 1'b1);
      collect("t3p", 0);
      check("t3p_const", 32'(got_sum), 32'h7BFF);
      send(16'hFBFF, 1'b0);
      send(16'hFBFF, 1'b1);
      collect("t3n", 0);
      check("t3n_const", 32'(got_sum), 32'hFBFF);

      // 4) rounding tie.
      send(16'h3C01, 1'b0);
      send(16'h1000, 1'b1);
      collect("t4", 0);
`ifdef FP16_DOT_ACC_RNE_EN
      check("t4_const", 32'(got_sum), 32'h3C02);
`else
      check("t4_const", 32'(got_sum), 32'h3C01);
`endif

      // 5) back-pressure, then next packet starts from +0.
      send(16'h4000, 1'b0);
      send(16'h3C00, 1'b1);
      collect("t5", 10);
      check("t5_const", 32'(got_sum), 32'h4200);
      send(16'h3C00, 1'b1);
      collect("t5b", 0);
      check("t5b_const", 32'(got_sum), 32'h3C00);

      // 6) reset while in ADD with a partial sum in the accumulator.
      send(16'h4000, 1'b0);
      send(16'h4400, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_acc = '0;
      model_cnt = 0;
      check("t6_rst_valid", 32'(out_valid), 32'd0);
      check("t6_rst_sum",   32'(out_sum),   32'd0);
      check("t6_rst_count", 32'(out_count), 32'd0);
      check("t6_rst_ready", 32'(in_ready),  32'd1);
      send(16'h3C00, 1'b1);
      collect("t6a", 0);
      check("t6a_const", 32'(got_sum), 32'h3C00);
      send(16'h0200, 1'b1);
      collect("t6b", 0);
      check("t6b_const", 32'(got_sum), 32'h0000);

      // Random packets against the exact model.
      for (int p = 0; p < 30; p++) begin
         int len;
         len = $urandom_range(6, 1);
         for (int i = 0; i < len; i++) send(rnd_fp(), (i == len - 1));
         collect("rand", 0);
      end

      // Long packet: element count saturates.
      for (int i = 0; i < 300; i++) send(rnd_fp(), (i == 299));
      collect("long", 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
